// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: op codes, FSM state encoding and bus constants shared by the GPIO RMW sequencer
package gpio_seq_pkg;
  localparam logic [2:0] OP_READ   = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_CLR    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] ST_INIT_D = 3'd0;
  localparam logic [2:0] ST_INIT_M = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_RD0    = 3'd3;
  localparam logic [2:0] ST_RD1    = 3'd4;
  localparam logic [2:0] ST_WR     = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [31:0] OFF_DATA = 32'd0;
  localparam logic [31:0] OFF_MODE = 32'd4;
  localparam logic [1:0] BUS_SIZE_WORD = 2'b10;
  function automatic logic is_rmw(input logic [2:0] op);
    return op == OP_SET || op == OP_CLR || op == OP_TOGGLE;
  endfunction
  function automatic logic is_rsvd(input logic [2:0] op);
    return op > OP_TOGGLE;
  endfunction
endpackage

// File: rtl/gpio_rmw_sequencer_arb.sv
// rr_arbiter2: two-way round-robin arbiter
//   clk, rst_n : clock, async active-low reset
//   req        : per-port request
//   take       : grant accepted this cycle, remember the winner
//   gnt        : index of the winning port
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);
  logic rr_last;
  assign gnt = &req ? ~rr_last : req[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_last <= 1'b1;
    else if (take) rr_last <= gnt;
endmodule

// File: rtl/gpio_rmw_sequencer.sv
// gpio_rmw_sequencer: arbitrates two requesters onto the GPIO bus and runs SET/CLR/TOGGLE as atomic RMW
//   req_*      : per-port request (valid, op, DATA/MODE select, value or mask), held until ack
//   ack, rdata : one-cycle completion pulse per port, result valid in that cycle
//   busy       : FSM not idle
//   bus_*      : word cycles towards the GPIO controller; bus_rdata is the shared data lines
module gpio_rmw_sequencer
  import gpio_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000,
  parameter int          NUM_PINS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic        req_sel0,
  input  logic        req_sel1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] bus_addr,
  output logic        bus_rw,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_wdata,
  output logic        bus_oe,
  input  logic [31:0] bus_rdata
);
  // wraps to all-ones when NUM_PINS is 32
  localparam logic [31:0] PIN_MASK = (32'd1 << NUM_PINS) - 32'd1;
  logic [2:0] state, nxt, op_q, op_in;
  logic sel_q, sel_in, gnt, gnt_q, take, wr_st, rd_st;
  logic [31:0] mask_q, data_q, mode_shadow, base, wval, wd_in;
  rr_arbiter2 u_arb (.clk(clk), .rst_n(rst_n), .req(req_valid), .take(take), .gnt(gnt));
  assign take = state == ST_IDLE && |req_valid;
  assign op_in = gnt ? req_op1 : req_op0;
  assign sel_in = gnt ? req_sel1 : req_sel0;
  assign wd_in = gnt ? req_wdata1 : req_wdata0;
  // MODE reads return pin levels, so a MODE RMW modifies the shadow instead of a bus read
  assign base = sel_q ? mode_shadow : data_q;
  assign wval = PIN_MASK & (op_q == OP_WRITE ? mask_q :
                            op_q == OP_SET   ? base | mask_q :
                            op_q == OP_CLR   ? base & ~mask_q : base ^ mask_q);
  assign nxt = state == ST_INIT_D ? ST_INIT_M :
               state == ST_INIT_M ? ST_IDLE :
               state == ST_IDLE   ? (!take ? ST_IDLE :
                                     is_rsvd(op_in) || (sel_in && op_in == OP_READ) ? ST_DONE :
                                     sel_in || op_in == OP_WRITE ? ST_WR : ST_RD0) :
               state == ST_RD0    ? ST_RD1 :
               state == ST_RD1    ? (is_rmw(op_q) ? ST_WR : ST_DONE) :
               state == ST_WR     ? ST_DONE : ST_IDLE;
  // gating with rst_n releases the bus the instant reset asserts, even though INIT_D is a write state
  assign wr_st = rst_n && (state == ST_INIT_D || state == ST_INIT_M || state == ST_WR);
  assign rd_st = rst_n && (state == ST_RD0 || state == ST_RD1);
  assign bus_rw = wr_st;
  assign bus_oe = wr_st;
  assign bus_addr = wr_st ? BASE_ADDR + (state == ST_INIT_M || (state == ST_WR && sel_q) ? OFF_MODE : OFF_DATA) :
                    rd_st ? BASE_ADDR + OFF_DATA : IDLE_ADDR;
  assign bus_wdata = rst_n && state == ST_WR ? wval : '0;
  assign bus_size = BUS_SIZE_WORD;
  assign busy = state != ST_IDLE;
  assign ack = state == ST_DONE ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  // data_q doubles as the sampled read value, the RMW base and the returned result
  assign rdata = data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT_D;
      op_q <= OP_READ;
      sel_q <= 1'b0;
      gnt_q <= 1'b0;
      mask_q <= '0;
      data_q <= '0;
      mode_shadow <= '0;
    end else begin
      state <= nxt;
      if (take) begin
        op_q <= op_in;
        sel_q <= sel_in;
        gnt_q <= gnt;
        mask_q <= wd_in;
        data_q <= sel_in && op_in == OP_READ ? mode_shadow : '0;
      end
      if (state == ST_RD1) data_q <= bus_rdata & PIN_MASK;
      if (state == ST_WR) begin
        data_q <= wval;
        if (sel_q) mode_shadow <= wval;
      end
    end
endmodule
